// File: rtl/div_unit_pkg.sv
// div_unit_pkg: state encoding, default widths and the divide-by-zero
// exception code shared between the divider and the control unit.
package div_unit_pkg;
    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = 6;
    localparam logic [4:0] EXC_DIV_ZERO = 5'h0f;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } div_state_t;
endpackage

// File: rtl/div_unit_if.sv
// div_unit_if: request/operand/result bundle between control unit and divider.
interface div_unit_if import div_unit_pkg::*; #(parameter int WIDTH = DIV_WIDTH);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    modport master (
        output start, dividend, divisor,
        input  busy, done, div_zero, hi, lo
    );
    modport slave (
        input  start, dividend, divisor,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/div_unit_step.sv
// div_step: one restoring-division iteration on unsigned magnitudes.
module div_step import div_unit_pkg::*; #(parameter int WIDTH = DIV_WIDTH) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_dvs,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_quo
);
    logic [WIDTH:0]   w_sh;
    logic [WIDTH-1:0] w_diff;
    logic             w_ge;
    always_comb begin
        w_sh   = {i_rem, i_quo[WIDTH-1]};
        w_ge   = w_sh >= {1'b0, i_dvs};
        // rem < divisor before the shift, so the difference always fits WIDTH bits
        w_diff = w_sh[WIDTH-1:0] - i_dvs;
        o_rem  = w_ge ? w_diff : w_sh[WIDTH-1:0];
        o_quo  = {i_quo[WIDTH-2:0], w_ge};
    end
endmodule

// File: rtl/div_unit.sv
// div_unit: multicycle signed divider for DIV; quotient to lo, remainder to hi,
// one restoring step per clock with sign fix-up in FINISH.
module div_unit import div_unit_pkg::*; #(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic       clk,
    input  logic       reset,
    div_unit_if.slave  bus
);
    div_state_t       r_state;
    div_state_t       w_next;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] w_rem;
    logic [WIDTH-1:0] w_quo;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sign_q;
    logic             r_sign_r;
    logic             r_zero;
    logic             r_done;
    logic             r_div_zero;
    logic             w_dz;

    assign w_dz         = bus.divisor == '0;
    assign bus.busy     = r_state == RUN;
    assign bus.done     = r_done;
    assign bus.div_zero = r_div_zero;
    assign bus.hi       = r_hi;
    assign bus.lo       = r_lo;

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem (r_rem),
        .i_quo (r_quo),
        .i_dvs (r_dvs),
        .o_rem (w_rem),
        .o_quo (w_quo)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = bus.start ? (w_dz ? FINISH : RUN) : IDLE;
            RUN:     w_next = (r_cnt == CNT_W'(1)) ? FINISH : RUN;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_rem      <= '0;
            r_quo      <= '0;
            r_dvs      <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_cnt      <= '0;
            r_sign_q   <= 1'b0;
            r_sign_r   <= 1'b0;
            r_zero     <= 1'b0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_done     <= r_state == FINISH;
            r_div_zero <= (r_state == FINISH) && r_zero;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_zero <= w_dz;
                        if (!w_dz) begin
                            r_quo    <= bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
                            r_dvs    <= bus.divisor[WIDTH-1] ? -bus.divisor : bus.divisor;
                            r_sign_q <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                            r_sign_r <= bus.dividend[WIDTH-1];
                            r_rem    <= '0;
                            r_cnt    <= CNT_W'(WIDTH);
                        end
                    end
                end
                RUN: begin
                    r_rem <= w_rem;
                    r_quo <= w_quo;
                    r_cnt <= r_cnt - CNT_W'(1);
                end
                FINISH: begin
                    if (!r_zero) begin
                        r_lo <= r_sign_q ? -r_quo : r_quo;
                        r_hi <= r_sign_r ? -r_rem : r_rem;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: randomized and directed DIV checks against a plain-arithmetic model.
module tb_div_unit;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    div_unit_if #(.WIDTH(32)) bus ();
    div_unit dut (.clk(clk), .reset(reset), .bus(bus));

    int n_chk = 0;
    int n_err = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // MIPS DIV: truncating quotient, remainder with dividend sign, zero divisor leaves hi/lo
    task automatic model(input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) begin
        end else if (a == 32'h8000_0000 && b == 32'hffff_ffff) begin
            m_lo = a;
            m_hi = 32'd0;
        end else begin
            m_lo = $signed(a) / $signed(b);
            m_hi = $signed(a) % $signed(b);
        end
    endtask

    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input int restart_at);
        int cyc;
        int busy_n;
        int extra;
        @(negedge clk);
        bus.start = 1'b1;
        bus.dividend = a;
        bus.divisor = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.dividend = $urandom;
        bus.divisor = $urandom;
        model(a, b);
        cyc = 0;
        busy_n = int'(bus.busy);
        while (!bus.done && cyc < 100) begin
            if (cyc == restart_at) bus.start = 1'b1;
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            cyc++;
            busy_n += int'(bus.busy);
        end
        check("latency", 32'(cyc), (b == 32'd0) ? 32'd1 : 32'd33);
        check("busy_cycles", 32'(busy_n), (b == 32'd0) ? 32'd0 : 32'd32);
        check("div_zero", 32'(bus.div_zero), 32'(b == 32'd0));
        check("lo", bus.lo, m_lo);
        check("hi", bus.hi, m_hi);
        @(posedge clk);
        #1;
        check("done_pulse", 32'(bus.done), 32'd0);
        check("div_zero_pulse", 32'(bus.div_zero), 32'd0);
        if (restart_at >= 0) begin
            extra = 0;
            repeat (40) begin
                @(posedge clk);
                #1;
                extra += int'(bus.done);
            end
            check("extra_done", 32'(extra), 32'd0);
        end
    endtask

    initial begin
        int extra;
        logic [31:0] a;
        logic [31:0] b;
        bus.start = 1'b0;
        bus.dividend = '0;
        bus.divisor = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        check("rst_hi", bus.hi, 32'd0);
        check("rst_lo", bus.lo, 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_div_zero", 32'(bus.div_zero), 32'd0);

        run_div(32'd100, 32'd7, -1);
        run_div(32'hffff_ff9c, 32'd7, -1);
        run_div(32'd100, 32'hffff_fff9, -1);
        run_div(32'd100, 32'd7, -1);
        run_div(32'd5, 32'd0, -1);
        run_div(32'h8000_0000, 32'hffff_ffff, 10);
        run_div(32'h8000_0000, 32'd1, -1);
        run_div(32'd0, 32'hffff_fff7, -1);

        @(negedge clk);
        bus.start = 1'b1;
        bus.dividend = 32'd1000;
        bus.divisor = 32'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        m_hi = '0;
        m_lo = '0;
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_hi", bus.hi, 32'd0);
        check("midrst_lo", bus.lo, 32'd0);
        check("midrst_done", 32'(bus.done), 32'd0);
        extra = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            extra += int'(bus.done) + int'(bus.busy);
        end
        check("midrst_quiet", 32'(extra), 32'd0);
        run_div(32'd1000, 32'd3, -1);

        repeat (40) begin
            a = $urandom;
            case ($urandom_range(0, 4))
                0: b = 32'd0;
                1: b = 32'($urandom_range(0, 15)) - 32'd8;
                2: b = {{16{1'b0}}, 16'($urandom)};
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 255)) - 32'd128;
            run_div(a, b, -1);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multicycle signed 32-bit divider for the DIV instruction.
- Produces quotient (LO) and remainder (HI). These feed the HI/LO data inputs of the 7-way register-writeback/ALU-source select mux.
- Started by the control unit. Reports completion and divide-by-zero, which the control unit routes to the exception path.
- One iteration per clock, restoring algorithm on operand magnitudes, with sign fix-up at the end.

Parameters:
- WIDTH, 32, operand and result width in bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- start  in  1  request a division; sampled only in IDLE.
- dividend  in  WIDTH  signed dividend (rs); captured when start is accepted.
- divisor  in  WIDTH  signed divisor (rt); captured when start is accepted.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse: hi/lo are valid, or div_zero is set.
- div_zero  out  1  one-cycle pulse, coincident with done, when the divisor was zero.
- hi  out  WIDTH  remainder, registered; held until the next successful division.
- lo  out  WIDTH  quotient, registered; held until the next successful division.

Behaviour:
- Reset (reset==0 at an edge): state=IDLE; busy, done, div_zero, hi, lo, counter and all internal registers set to 0. Reset has priority over everything, including mid-RUN; the in-flight division is discarded and hi/lo read 0.
- States: IDLE, RUN, FINISH.
- IDLE:
  - start==1, divisor!=0: capture |dividend|, |divisor|, sign_q = dividend[MSB] ^ divisor[MSB], sign_r = dividend[MSB]. Clear the partial remainder, set counter=WIDTH, go to RUN.
  - start==1, divisor==0: go to FINISH with the zero flag set; hi/lo unchanged.
  - start==0: stay in IDLE.
- RUN, one step per cycle:
  - Shift {rem, quo} left by one, bringing in the next dividend bit.
  - If rem >= |divisor|, subtract and set quo[0]=1.
  - Decrement the counter. After the step with counter==1 (the WIDTH-th step), go to FINISH.
  - start is ignored.
  - Comparison and subtraction use WIDTH+1 bits, so |-2^31| is handled unsigned.
- FINISH (one cycle):
  - Normal case: lo = sign_q ? -quo : quo; hi = sign_r ? -rem : rem.
  - Zero case: hi/lo untouched.
  - Then go to IDLE.
  - start is ignored here. It is honoured in IDLE only, so back-to-back requests are accepted the cycle after done.
- Registered outputs and timing:
  - done and div_zero are registered and high during the cycle after the FINISH edge, for one cycle only.
  - busy=1 exactly while state==RUN.
- Latency: start sampled at edge E0. Normal case: done high after edge E0+WIDTH+1 (33 cycles for WIDTH=32). Zero divisor: done and div_zero high after edge E0+1.
- Semantics:
  - Quotient truncates toward zero; remainder takes the dividend's sign (MIPS DIV).
  - -2^31 / -1 yields lo=0x80000000, hi=0, with no flag.
  - 0 / x yields hi=lo=0.
- Operands may change after acceptance without affecting the result.

Decomposition:
- Shared package: state encoding (IDLE=2'd0, RUN=2'd1, FINISH=2'd2), WIDTH default, and the divide-by-zero exception code used by the control unit.
- One natural sub-module: div_step. It is combinational: takes {rem, quo, divisor_mag} and returns the next {rem, quo}, and is instantiated once in RUN.
- The FSM, counter and sign fix-up stay in div_unit.

Test Plan:
- Reset low for 2 cycles, then release -> hi=lo=0, busy=done=div_zero=0.
- start with dividend=100, divisor=7 -> busy for 32 cycles; done pulses 33 cycles after start; lo=14, hi=2.
- dividend=-100 (0xFFFFFF9C), divisor=7 -> lo=0xFFFFFFF2 (-14), hi=0xFFFFFFFE (-2). dividend=100, divisor=-7 -> lo=-14, hi=2.
- Prior result lo=14, hi=2; then dividend=5, divisor=0 -> done and div_zero high one cycle after start; lo=14, hi=2 unchanged; busy never high.
- dividend=0x80000000, divisor=0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0. A second start pulse asserted at cycle 10 of RUN is ignored: done pulses only once.
- Reset asserted at cycle 15 of RUN -> next cycle state=IDLE, hi=lo=0, busy=0, no done pulse; a new start then completes normally.
